// File: rtl/led_binary_counter.sv
// -----------------------------------------------------------------------------
// led_binary_counter
//
// Free-running binary counter that drives a bank of LEDs with its current
// count. A prescaler slows the count rate so that the pattern is visible
// on a fast board clock. The counter advances once every DIV clock cycles.
//
// Parameters
//   WIDTH : counter / LED vector width in bits (>= 1)
//   DIV   : prescale ratio, clock cycles per count step (>= 1)
//
// Ports
//   CLK : input,  system clock; all state updates on its rising edge
//   RST : input,  synchronous active-high reset
//   OUT : output, WIDTH bits, LED drive = current count (bit 0 = LSB),
//         driven straight from a register
// -----------------------------------------------------------------------------
module led_binary_counter #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [WIDTH-1:0] OUT
);

    // A one-bit prescaler is kept even when DIV=1 so the logic below
    // needs no special case; it simply never leaves zero.
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

    logic [WIDTH-1:0] r_cnt;
    logic [PRE_W-1:0] r_pre;
    logic             w_tick;

    // Tick marks the last cycle of each prescale period.
    always_comb begin
        w_tick = 1'b0;
        if (r_pre == PRE_MAX) begin
            w_tick = 1'b1;
        end else begin
            w_tick = 1'b0;
        end
    end

    // Prescaler and count registers; reset wins over tick so a reset
    // mid-period restarts with a full DIV period.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= CNT_ZERO;
            r_pre <= PRE_ZERO;
        end else if (w_tick) begin
            r_pre <= PRE_ZERO;
            r_cnt <= r_cnt + CNT_ONE;   // wraps modulo 2^WIDTH
        end else begin
            r_pre <= r_pre + PRE_ONE;
            r_cnt <= r_cnt;
        end
    end

    assign OUT = r_cnt;

endmodule

// File: tb/tb_led_binary_counter.sv
// -----------------------------------------------------------------------------
// tb_led_binary_counter
//
// Directed bench for led_binary_counter. Two instances share one 20 ns
// clock: u_div1 (DIV=1) and u_div4 (DIV=4), each with its own reset.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_led_binary_counter;

    logic       clk;
    logic       rst1;
    logic       rst4;
    logic [7:0] out1;
    logic [7:0] out4;

    int tests_run;
    int tests_failed;

    led_binary_counter #(.WIDTH(8), .DIV(1)) u_div1 (
        .CLK (clk),
        .RST (rst1),
        .OUT (out1)
    );

    led_binary_counter #(.WIDTH(8), .DIV(4)) u_div4 (
        .CLK (clk),
        .RST (rst4),
        .OUT (out4)
    );

    // 20 ns clock, rising edges at 10, 30, 50 ns ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One reset edge on DIV=1 instance, then counting 1..5.
    task automatic test_reset();
        rst1 = 1'b1;
        step();
        tests_run++;
        if (out1 !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_div1: got %0d expected 0", out1);
        end
        rst1 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            tests_run++;
            if (out1 !== 8'(i)) begin
                tests_failed++;
                $display("FAIL count_div1 edge %0d: got %0d expected %0d", i, out1, i);
            end
        end
    endtask

    // 257 edges after reset: passes 254, 255, 0, 1 with no gap.
    task automatic test_wrap();
        logic [7:0] exp;
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        for (int i = 1; i <= 257; i++) begin
            step();
            exp = 8'(i % 256);
            tests_run++;
            if (out1 !== exp) begin
                tests_failed++;
                $display("FAIL wrap_div1 edge %0d: got %0d expected %0d", i, out1, exp);
            end
        end
    endtask

    // Reset while OUT=0x5A clears on that edge, then 1 on the next.
    task automatic test_mid_reset();
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        for (int i = 0; i < 8'h5A; i++) begin
            step();
        end
        tests_run++;
        if (out1 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL midrst_pre_div1: got %0h expected 5a", out1);
        end
        rst1 = 1'b1;
        step();
        tests_run++;
        if (out1 !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_clear_div1: got %0h expected 0", out1);
        end
        rst1 = 1'b0;
        step();
        tests_run++;
        if (out1 !== 8'h01) begin
            tests_failed++;
            $display("FAIL midrst_resume_div1: got %0h expected 1", out1);
        end
    endtask

    // Reset held 10 edges keeps OUT at 0, then counting resumes 1,2,3.
    task automatic test_long_reset();
        rst1 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            tests_run++;
            if (out1 !== 8'h00) begin
                tests_failed++;
                $display("FAIL longrst_div1 edge %0d: got %0d expected 0", i, out1);
            end
        end
        rst1 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if (out1 !== 8'(i)) begin
                tests_failed++;
                $display("FAIL longrst_resume_div1 edge %0d: got %0d expected %0d", i, out1, i);
            end
        end
    endtask

    // DIV=4: OUT = floor(edge/4) for edges 1..12 after release.
    task automatic test_div4_latency();
        logic [7:0] exp;
        rst4 = 1'b1;
        step();
        tests_run++;
        if (out4 !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_div4: got %0d expected 0", out4);
        end
        rst4 = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            exp = 8'(e / 4);
            tests_run++;
            if (out4 !== exp) begin
                tests_failed++;
                $display("FAIL count_div4 edge %0d: got %0d expected %0d", e, out4, exp);
            end
        end
    endtask

    // DIV=4: reset when prescaler is 2; next increment must take 4 edges.
    task automatic test_div4_mid_reset();
        logic [7:0] exp;
        rst4 = 1'b1;
        step();
        rst4 = 1'b0;
        // After 6 edges: OUT=1, prescaler=2.
        for (int e = 1; e <= 6; e++) begin
            step();
        end
        tests_run++;
        if (out4 !== 8'h01) begin
            tests_failed++;
            $display("FAIL midrst_pre_div4: got %0d expected 1", out4);
        end
        rst4 = 1'b1;
        step();
        tests_run++;
        if (out4 !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_clear_div4: got %0d expected 0", out4);
        end
        rst4 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp = 8'(e / 4);
            tests_run++;
            if (out4 !== exp) begin
                tests_failed++;
                $display("FAIL midrst_resume_div4 edge %0d: got %0d expected %0d", e, out4, exp);
            end
        end
    endtask

    // Sequence all scenarios and print the summary.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst1 = 1'b1;
        rst4 = 1'b1;
        #25;
        test_reset();
        test_wrap();
        test_mid_reset();
        test_long_reset();
        test_div4_latency();
        test_div4_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
